pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Generic, parametrised pipeline-boundary register for the five-stage CPU. Replaces the fixed per-boundary register/signal pairs, for example EX->MEM.
- Carries a data bundle and a control bundle between stages with a valid/ready handshake, stall back-pressure and synchronous flush.
- Contains an optional skid entry, so upstream ready does not combinationally depend on downstream ready.
- One instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 96: width of the data bundle (e.g. PC, IR, operands, write-back register number packed).
- CTRL_W, 8: width of the control bundle. It is zeroed on flush or bubble so downstream side effects are killed.
- SKID, 1: 1 = two-entry elastic stage (main + skid); 0 = single register with combinational ready.

Ports:
- clk, in, 1: clock, rising edge.
- CLR, in, 1: synchronous active-high reset.
- flush, in, 1: synchronous kill of all held and incoming beats.
- in_valid, in, 1: upstream beat present.
- in_ready, out, 1: stage can accept the beat.
- in_data, in, DATA_W: upstream data bundle.
- in_ctrl, in, CTRL_W: upstream control bundle.
- out_valid, out, 1: beat presented downstream.
- out_ready, in, 1: downstream accepts; low = stall.
- out_data, out, DATA_W: held data.
- out_ctrl, out, CTRL_W: held control; all-zero whenever out_valid=0.

Behaviour:
- Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready; evaluated at posedge clk.
- Reset: CLR=1 has priority over everything. Next cycle out_valid=0, out_data=0, out_ctrl=0, skid empty, in_ready=1.
- Flush (CLR=0, flush=1):
  - Main and skid entries are invalidated, and their ctrl cleared to 0, at the next edge.
  - A beat accepted in the same cycle is discarded.
  - out_data may hold its old value.
  - in_ready=1 the cycle after.
- SKID=1, states EMPTY (no beat), FULL1 (main only), FULL2 (main+skid):
  - EMPTY --accept--> FULL1; main <= in.
  - FULL1, accept & emit: stays FULL1; main <= in.
  - FULL1, accept & !emit: -> FULL2; skid <= in.
  - FULL1, !accept & emit: -> EMPTY.
  - FULL2, emit: -> FULL1; main <= skid. No accept is possible here.
  - in_ready = !FULL2. It is a registered state decode, with no path from out_ready.
  - out_valid = (state != EMPTY).
  - Latency: 1 cycle in -> out. Full throughput with out_ready=1.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - On accept: main <= in, out_valid <= 1.
  - On emit without accept: out_valid <= 0.
  - Latency 1; full throughput.
- Stall (out_ready=0): out_valid/out_data/out_ctrl are held stable until emit. Required for MEM-stage write correctness.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except on flush or CLR.
- Ctrl gating: out_ctrl is forced to 0 when out_valid=0. A bubble therefore never asserts RegWrite/MemWrite-type bits.
- Simultaneous flush & CLR: CLR wins; the result is identical anyway.
- Mid-stall flush: the held beat is dropped and the stall is released.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments each cycle out_valid & !out_ready.
  - bubble_cnt increments each cycle !out_valid & !flush.
  - Both are cleared by CLR and wrap at 2^32.
  - Neither counter affects the datapath.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - state encoding localparams ST_EMPTY=2'd0, ST_FULL1=2'd1, ST_FULL2=2'd2;
  - standard bundle-width constants per boundary (EXMEM_DATA_W, EXMEM_CTRL_W, etc.);
  - ctrl bit-index constants (RegWrite, MemWrite, ...).
- One sub-module: pipe_skid_entry (a DATA_W+CTRL_W register with load enable and valid bit), instantiated twice for main and skid.

Test Plan:
- CLR held 2 cycles while in_valid=1, in_data=0xA5...: out_valid=0, out_ctrl=0, in_ready=1 after release; no beat emitted.
- Streaming, out_ready=1, beats D0..D7 (in_ctrl=8'h81) on consecutive cycles: D0..D7 appear in order, each 1 cycle later; no gaps.
- SKID=1, out_ready=0 while sending D0,D1,D2: D0 on the output stable; in_ready falls after D1 is accepted; D2 held upstream. Releasing out_ready yields D0,D1,D2 in order.
- flush asserted in FULL2 with in_valid=1 (D3): next cycle out_valid=0, out_ctrl=0, in_ready=1; D3 never appears at the output.
- SKID=0, out_ready toggling 1,0,1,0: in_ready tracks !out_valid|out_ready in the same cycle; no loss or duplication over 16 beats.
- With PIPE_STAGE_STATS_EN, 5 stall cycles + 3 idle cycles: stall_cnt=5, bubble_cnt=3; both are 0 after CLR.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-boundary registers of the five-stage CPU.
// Contents:
//   - occupancy encoding of an elastic stage (EMPTY / FULL1 / FULL2)
//   - standard data/ctrl bundle widths per stage boundary
//   - bit positions inside the control bundle
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL1 = 2'd1;
  localparam logic [1:0] ST_FULL2 = 2'd2;

  typedef enum logic [1:0] {
    StEmpty = ST_EMPTY,
    StFull1 = ST_FULL1,
    StFull2 = ST_FULL2
  } pipe_state_e;

  // Bundle widths per boundary
  localparam int unsigned IFID_DATA_W  = 64;   // PC, IR
  localparam int unsigned IFID_CTRL_W  = 8;
  localparam int unsigned IDEX_DATA_W  = 133;  // PC, IR, rs1, rs2 values, rd
  localparam int unsigned IDEX_CTRL_W  = 8;
  localparam int unsigned EXMEM_DATA_W = 96;   // PC, ALU result, store data
  localparam int unsigned EXMEM_CTRL_W = 8;
  localparam int unsigned MEMWB_DATA_W = 69;   // result, load data, rd
  localparam int unsigned MEMWB_CTRL_W = 8;

  // Control bundle bit indices
  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_WRITE  = 1;
  localparam int unsigned CTRL_MEM_READ   = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 3;
  localparam int unsigned CTRL_BRANCH     = 4;
  localparam int unsigned CTRL_JUMP       = 5;
  localparam int unsigned CTRL_ALU_SRC    = 6;
  localparam int unsigned CTRL_HALT       = 7;

endpackage

// File: rtl/pipe_skid_entry.sv
// One storage entry of an elastic pipeline stage: data + ctrl register with a
// load enable and a valid bit.
// Ports:
//   clk        rising-edge clock
//   clr        synchronous reset: valid, data and ctrl all cleared
//   kill       flush: valid and ctrl cleared, data left as is
//   load       capture data_nxt/ctrl_nxt
//   valid_nxt  valid bit for the next cycle
//   data_nxt   incoming data bundle
//   ctrl_nxt   incoming control bundle
//   valid      entry holds a beat
//   data       held data bundle
//   ctrl       held control bundle (raw, not gated by valid)
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              kill,
  input  logic              load,
  input  logic              valid_nxt,
  input  logic [DATA_W-1:0] data_nxt,
  input  logic [CTRL_W-1:0] ctrl_nxt,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clk) begin
    if (clr) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (kill) begin
      // A beat loaded in the same cycle is dropped too.
      valid <= 1'b0;
      ctrl  <= '0;
    end else begin
      valid <= valid_nxt;
      if (load) begin
        data <= data_nxt;
        ctrl <= ctrl_nxt;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Generic pipeline-boundary register with valid/ready handshake, stall
// back-pressure and synchronous flush. One instance per stage boundary.
// Parameters:
//   DATA_W  data bundle width
//   CTRL_W  control bundle width (zeroed on flush and on bubbles)
//   SKID    1: main + skid entry, in_ready is a registered decode
//           0: single entry, in_ready = !out_valid | out_ready
// Ports:
//   clk, CLR (sync active-high reset), flush (sync kill of held/incoming beats)
//   in_valid/in_ready/in_data/in_ctrl      upstream side
//   out_valid/out_ready/out_data/out_ctrl  downstream side
// Build option PIPE_STAGE_STATS_EN adds stall_cnt and bubble_cnt outputs.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  logic              accept;
  logic              emit;
  logic              main_load;
  logic              main_valid_nxt;
  logic [DATA_W-1:0] main_data_nxt;
  logic [CTRL_W-1:0] main_ctrl_nxt;
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk       (clk),
    .clr       (CLR),
    .kill      (flush),
    .load      (main_load),
    .valid_nxt (main_valid_nxt),
    .data_nxt  (main_data_nxt),
    .ctrl_nxt  (main_ctrl_nxt),
    .valid     (main_valid),
    .data      (main_data),
    .ctrl      (main_ctrl)
  );

  assign out_valid = main_valid;
  assign out_data  = main_data;
  // Bubbles must never carry RegWrite/MemWrite-type bits downstream.
  assign out_ctrl  = main_valid ? main_ctrl : '0;

  if (SKID != 0) begin : g_skid
    pipe_state_e       state_q, state_d;
    logic              skid_load;
    logic              skid_valid_nxt;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    always_ff @(posedge clk) begin
      if (CLR || flush) begin
        state_q <= StEmpty;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d       = state_q;
      main_load     = 1'b0;
      skid_load     = 1'b0;
      main_data_nxt = in_data;
      main_ctrl_nxt = in_ctrl;
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StFull1;
            main_load = 1'b1;
          end
        end
        StFull1: begin
          if (accept && emit) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = StFull2;
            skid_load = 1'b1;
          end else if (emit) begin
            state_d = StEmpty;
          end
        end
        StFull2: begin
          // in_ready is low here, so only the skid beat can move forward.
          if (emit) begin
            state_d       = StFull1;
            main_load     = 1'b1;
            main_data_nxt = skid_data;
            main_ctrl_nxt = skid_ctrl;
          end
        end
        default: state_d = StEmpty;
      endcase
      main_valid_nxt = (state_d != StEmpty);
      skid_valid_nxt = (state_d == StFull2);
    end

    pipe_skid_entry #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_skid (
      .clk       (clk),
      .clr       (CLR),
      .kill      (flush),
      .load      (skid_load),
      .valid_nxt (skid_valid_nxt),
      .data_nxt  (in_data),
      .ctrl_nxt  (in_ctrl),
      .valid     (skid_valid),
      .data      (skid_data),
      .ctrl      (skid_ctrl)
    );

    // Skid occupancy is FULL2; registered, so no path from out_ready.
    assign in_ready = ~skid_valid;
  end else begin : g_noskid
    assign in_ready = ~main_valid | out_ready;

    always_comb begin
      main_load      = accept;
      main_data_nxt  = in_data;
      main_ctrl_nxt  = in_ctrl;
      main_valid_nxt = main_valid;
      if (accept) begin
        main_valid_nxt = 1'b1;
      end else if (emit) begin
        main_valid_nxt = 1'b0;
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  always_ff @(posedge clk) begin
    if (CLR) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (!out_valid && !flush) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: instance a uses SKID=1, instance b SKID=0.
module tb_pipe_stage_elastic;

  localparam int unsigned DW = 96;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          clr;
  logic          flush;
  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]   a_stall_cnt, a_bubble_cnt, b_stall_cnt, b_bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_a (
    .clk        (clk),
    .CLR        (clr),
    .flush      (flush),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_data    (a_in_data),
    .in_ctrl    (a_in_ctrl),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_data   (a_out_data),
    .out_ctrl   (a_out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt  (a_stall_cnt),
    .bubble_cnt (a_bubble_cnt)
`endif
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_b (
    .clk        (clk),
    .CLR        (clr),
    .flush      (flush),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_data    (b_in_data),
    .in_ctrl    (b_in_ctrl),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_data   (b_out_data),
    .out_ctrl   (b_out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt  (b_stall_cnt),
    .bubble_cnt (b_bubble_cnt)
`endif
  );

  function automatic logic [DW-1:0] dv(input int k);
    return {32'hC0DE0000, 32'h0, 32'(k)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic mv, exp_rdy, acc, emt;
    int   tx, rx;

    // Reset held two cycles with a beat offered on both instances
    clr = 1'b1; flush = 1'b0;
    a_in_valid = 1'b1; a_in_data = {3{32'hA5A5A5A5}}; a_in_ctrl = 8'hFF; a_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = {3{32'hA5A5A5A5}}; b_in_ctrl = 8'hFF; b_out_ready = 1'b1;
    cyc();
    cyc();
    clr = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    #1;
    chk("rst_a_out_valid", a_out_valid, 1'b0);
    chk("rst_a_out_ctrl",  a_out_ctrl,  8'h00);
    chk("rst_a_out_data",  a_out_data,  96'h0);
    chk("rst_a_in_ready",  a_in_ready,  1'b1);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    chk("rst_b_out_ctrl",  b_out_ctrl,  8'h00);
    chk("rst_b_in_ready",  b_in_ready,  1'b1);
    cyc();
    chk("rst_a_no_emit", a_out_valid, 1'b0);

    // Streaming D0..D7 with out_ready high
    a_in_ctrl = 8'h81;
    for (int k = 0; k < 8; k++) begin
      a_in_valid = 1'b1; a_in_data = dv(k);
      cyc();
      chk("strm_valid", a_out_valid, 1'b1);
      chk("strm_data",  a_out_data,  dv(k));
      chk("strm_ctrl",  a_out_ctrl,  8'h81);
      chk("strm_ready", a_in_ready,  1'b1);
    end
    a_in_valid = 1'b0;
    cyc();
    chk("strm_end_valid", a_out_valid, 1'b0);
    chk("strm_end_ctrl",  a_out_ctrl,  8'h00);

    // Stall: D0 held, skid fills with D1, D2 held upstream
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = dv(16'h10);
    cyc();
    chk("stall_d0",     a_out_data, dv(16'h10));
    chk("stall_rdy1",   a_in_ready, 1'b1);
    a_in_data = dv(16'h11);
    cyc();
    chk("stall_d0_hold", a_out_data, dv(16'h10));
    chk("stall_rdy0",    a_in_ready, 1'b0);
    a_in_data = dv(16'h12);
    cyc();
    chk("stall_hold_v", a_out_valid, 1'b1);
    chk("stall_hold_d", a_out_data,  dv(16'h10));
    chk("stall_hold_c", a_out_ctrl,  8'h81);
    chk("stall_hold_r", a_in_ready,  1'b0);
    cyc();
    chk("stall_hold_d2", a_out_data, dv(16'h10));
    a_out_ready = 1'b1;
    cyc();
    chk("rel_d1",  a_out_data, dv(16'h11));
    chk("rel_rdy", a_in_ready, 1'b1);
    cyc();
    chk("rel_d2", a_out_data,  dv(16'h12));
    chk("rel_v2", a_out_valid, 1'b1);
    a_in_valid = 1'b0;
    cyc();
    chk("rel_empty", a_out_valid, 1'b0);

    // Flush while FULL2 with D3 offered
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = dv(16'h20);
    cyc();
    a_in_data = dv(16'h21);
    cyc();
    chk("fl_full2_rdy", a_in_ready, 1'b0);
    a_in_data = dv(16'h23); flush = 1'b1;
    cyc();
    flush = 1'b0; a_in_valid = 1'b0;
    chk("fl_valid", a_out_valid, 1'b0);
    chk("fl_ctrl",  a_out_ctrl,  8'h00);
    chk("fl_rdy",   a_in_ready,  1'b1);
    a_out_ready = 1'b1;
    cyc();
    chk("fl_no_d3", a_out_valid, 1'b0);

    // Flush discards a beat accepted in the same cycle
    a_in_valid = 1'b1; a_in_data = dv(16'h24); flush = 1'b1;
    cyc();
    flush = 1'b0; a_in_valid = 1'b0;
    chk("fl_acc_valid", a_out_valid, 1'b0);
    cyc();
    chk("fl_acc_valid2", a_out_valid, 1'b0);

    // SKID=0: out_ready toggling, 16 beats, small valid-bit model
    b_in_ctrl = 8'h81; mv = 1'b0; tx = 0; rx = 0;
    for (int c = 0; c < 100 && rx < 16; c++) begin
      b_out_ready = (c % 2 == 0);
      b_in_valid  = (tx < 16);
      b_in_data   = dv(256 + tx);
      #1;
      exp_rdy = ~mv | b_out_ready;
      chk("b_in_ready",  b_in_ready,  exp_rdy);
      chk("b_out_valid", b_out_valid, mv);
      if (mv) chk("b_out_data", b_out_data, dv(256 + rx));
      acc = b_in_valid & exp_rdy;
      emt = mv & b_out_ready;
      if (emt) rx++;
      if (acc) begin
        mv = 1'b1;
        tx++;
      end else if (emt) begin
        mv = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    chk("b_rx_count", rx, 16);
    chk("b_tx_count", tx, 16);

`ifdef PIPE_STAGE_STATS_EN
    // 3 idle cycles then 5 stall cycles
    clr = 1'b1;
    cyc();
    clr = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    chk("st_clr_stall",  a_stall_cnt,  32'd0);
    chk("st_clr_bubble", a_bubble_cnt, 32'd0);
    cyc();
    cyc();
    a_in_valid = 1'b1; a_in_data = dv(16'h30); a_out_ready = 1'b0;
    cyc();
    a_in_valid = 1'b0;
    repeat (5) cyc();
    chk("st_stall",  a_stall_cnt,  32'd5);
    chk("st_bubble", a_bubble_cnt, 32'd3);
    clr = 1'b1;
    cyc();
    clr = 1'b0; a_out_ready = 1'b1;
    chk("st_clr2_stall",  a_stall_cnt,  32'd0);
    chk("st_clr2_bubble", a_bubble_cnt, 32'd0);
    chk("st_b_stall",     b_stall_cnt,  32'd0);
    chk("st_b_bubble",    b_bubble_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
